p405s_timer_pit: RTL and testbench

P405S_TIMER_PIT -- requirements
Module: p405s_timerPit

---
 rtl/p405s_timer_pit_pkg.sv | 27 ++
 rtl/p405s_timerPitDec.sv | 15 +
 rtl/p405s_timer_pit.sv | 120 ++++++++++++
 tb/tb_p405s_timer_pit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/p405s_timer_pit_pkg.sv
// rtl/p405s_timer_pit_pkg.sv - shared constants and helpers for the PIT timer slice
package p405s_timer_pit_pkg;

  localparam int PIT_W = 32;

  // SPR bit positions use big-endian numbering: bit 0 is the MSB of the word.
  localparam int TCR_PIE_BIT = 5;
  localparam int TCR_ARE_BIT = 9;
  localparam int TSR_PIS_BIT = 4;

  typedef enum logic [1:0] {
    PIT_HOLD   = 2'd0,
    PIT_LOAD   = 2'd1,
    PIT_DEC    = 2'd2,
    PIT_EXPIRE = 2'd3
  } pit_action_e;

  // Map a big-endian SPR bit number onto the descending [31:0] vectors used in RTL.
  function automatic int spr_bit(input int be_bit);
    return (PIT_W - 1) - be_bit;
  endfunction

  function automatic logic spr_write(input logic mt_spr, input logic dcd, input logic hold);
    return mt_spr & dcd & ~hold;
  endfunction

endpackage

// File: rtl/p405s_timerPitDec.sv
// rtl/p405s_timerPitDec.sv - 32-bit decrementer with one/zero detection
module p405s_timerPitDec
  import p405s_timer_pit_pkg::*;
(
  input  logic [PIT_W-1:0] value_i,
  output logic [PIT_W-1:0] dec_o,
  output logic             is_one_o,
  output logic             is_zero_o
);

  assign dec_o     = value_i - {{(PIT_W-1){1'b0}}, 1'b1};
  assign is_one_o  = (value_i == {{(PIT_W-1){1'b0}}, 1'b1});
  assign is_zero_o = (value_i == '0);

endmodule

// File: rtl/p405s_timer_pit.sv
// rtl/p405s_timer_pit.sv - programmable interval timer with auto-reload and PIS status
module p405s_timer_pit
  import p405s_timer_pit_pkg::*;
(
  input  logic             CB,
  input  logic             resetCore,
  input  logic             timerTic,
  input  logic             freezeTimersNEG,
  input  logic             PCL_mtSPR,
  input  logic             PCL_sprHold,
  input  logic [PIT_W-1:0] EXE_sprDataBus,
  input  logic             pitDcd,
  input  logic             tcrDcd,
  input  logic             tsrDcd,
  output logic [PIT_W-1:0] pitL2,
  output logic             tcrPieL2,
  output logic             tcrAreL2,
  output logic             tsrPisL2,
  output logic             TIM_pitIntReq
);

  logic [PIT_W-1:0] pit_q, pit_d;
  logic [PIT_W-1:0] reload_q;
  logic             tcr_pie_q, tcr_are_q;
  logic             tsr_pis_q, tsr_pis_d;

  logic             wr_pit, wr_tcr, wr_tsr;
  logic             dec_en, pit_en, pis_set;
  logic [PIT_W-1:0] pit_dec;
  logic             pit_is_one, pit_is_zero;
  pit_action_e      pit_action;

  assign wr_pit = spr_write(PCL_mtSPR, pitDcd, PCL_sprHold);
  assign wr_tcr = spr_write(PCL_mtSPR, tcrDcd, PCL_sprHold);
  assign wr_tsr = spr_write(PCL_mtSPR, tsrDcd, PCL_sprHold);

  p405s_timerPitDec u_dec (
    .value_i   (pit_q),
    .dec_o     (pit_dec),
    .is_one_o  (pit_is_one),
    .is_zero_o (pit_is_zero)
  );

  // A zero count never decrements, so the timer parks at 0 instead of wrapping.
  assign dec_en = timerTic & freezeTimersNEG & ~pit_is_zero;

  always_comb begin
    pit_action = PIT_HOLD;
    if (wr_pit) begin
      pit_action = PIT_LOAD;
    end else if (dec_en) begin
      pit_action = pit_is_one ? PIT_EXPIRE : PIT_DEC;
    end
  end

  always_comb begin
    pit_d = pit_q;
    case (pit_action)
      PIT_LOAD:   pit_d = EXE_sprDataBus;
      PIT_DEC:    pit_d = pit_dec;
      PIT_EXPIRE: pit_d = tcr_are_q ? reload_q : '0;
      default:    pit_d = pit_q;
    endcase
  end

  assign pit_en  = (pit_action != PIT_HOLD);
  assign pis_set = (pit_action == PIT_EXPIRE);

  // The expiry set is evaluated last so it wins over a same-cycle write-1-to-clear.
  always_comb begin
    tsr_pis_d = tsr_pis_q;
    if (wr_tsr && EXE_sprDataBus[spr_bit(TSR_PIS_BIT)]) begin
      tsr_pis_d = 1'b0;
    end
    if (pis_set) begin
      tsr_pis_d = 1'b1;
    end
  end

  always_ff @(posedge CB or posedge resetCore) begin
    if (resetCore) begin
      pit_q <= '0;
    end else if (pit_en) begin
      pit_q <= pit_d;
    end
  end

  always_ff @(posedge CB or posedge resetCore) begin
    if (resetCore) begin
      reload_q <= '0;
    end else if (wr_pit) begin
      reload_q <= EXE_sprDataBus;
    end
  end

  always_ff @(posedge CB or posedge resetCore) begin
    if (resetCore) begin
      tcr_pie_q <= 1'b0;
      tcr_are_q <= 1'b0;
    end else if (wr_tcr) begin
      tcr_pie_q <= EXE_sprDataBus[spr_bit(TCR_PIE_BIT)];
      tcr_are_q <= EXE_sprDataBus[spr_bit(TCR_ARE_BIT)];
    end
  end

  always_ff @(posedge CB or posedge resetCore) begin
    if (resetCore) begin
      tsr_pis_q <= 1'b0;
    end else begin
      tsr_pis_q <= tsr_pis_d;
    end
  end

  assign pitL2         = pit_q;
  assign tcrPieL2      = tcr_pie_q;
  assign tcrAreL2      = tcr_are_q;
  assign tsrPisL2      = tsr_pis_q;
  assign TIM_pitIntReq = tsr_pis_q & tcr_pie_q;

endmodule

// File: tb/tb_p405s_timer_pit.sv
// tb/tb_p405s_timer_pit.sv - vector table, corner sequences and random model checks for the PIT
module tb_p405s_timer_pit;

  logic        CB = 1'b0;
  logic        resetCore = 1'b1;
  logic        timerTic = 1'b0;
  logic        freezeTimersNEG = 1'b1;
  logic        PCL_mtSPR = 1'b0;
  logic        PCL_sprHold = 1'b0;
  logic [31:0] EXE_sprDataBus = 32'h0;
  logic        pitDcd = 1'b0;
  logic        tcrDcd = 1'b0;
  logic        tsrDcd = 1'b0;
  logic [31:0] pitL2;
  logic        tcrPieL2, tcrAreL2, tsrPisL2, TIM_pitIntReq;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [2:0] S_NONE = 3'b000;
  localparam logic [2:0] S_PIT  = 3'b100;
  localparam logic [2:0] S_TCR  = 3'b010;
  localparam logic [2:0] S_TSR  = 3'b001;

  typedef struct {
    logic [2:0]  sel;
    logic        tic;
    logic        hold;
    logic [31:0] data;
    logic [31:0] e_pit;
    logic        e_pis;
    logic        e_pie;
    logic        e_are;
    logic        e_irq;
  } vec_t;

  vec_t tbl[$];

  p405s_timer_pit dut (
    .CB              (CB),
    .resetCore       (resetCore),
    .timerTic        (timerTic),
    .freezeTimersNEG (freezeTimersNEG),
    .PCL_mtSPR       (PCL_mtSPR),
    .PCL_sprHold     (PCL_sprHold),
    .EXE_sprDataBus  (EXE_sprDataBus),
    .pitDcd          (pitDcd),
    .tcrDcd          (tcrDcd),
    .tsrDcd          (tsrDcd),
    .pitL2           (pitL2),
    .tcrPieL2        (tcrPieL2),
    .tcrAreL2        (tcrAreL2),
    .tsrPisL2        (tsrPisL2),
    .TIM_pitIntReq   (TIM_pitIntReq)
  );

  always #5 CB = ~CB;

  function automatic vec_t mk(input logic [2:0] sel, input logic tic, input logic hold,
                              input logic [31:0] data, input logic [31:0] e_pit,
                              input logic e_pis, input logic e_pie, input logic e_are,
                              input logic e_irq);
    vec_t v;
    v.sel = sel; v.tic = tic; v.hold = hold; v.data = data;
    v.e_pit = e_pit; v.e_pis = e_pis; v.e_pie = e_pie; v.e_are = e_are; v.e_irq = e_irq;
    return v;
  endfunction

  task automatic step(input logic mt, input logic [2:0] sel, input logic tic,
                      input logic hold, input logic frz, input logic [31:0] data);
    PCL_mtSPR = mt;
    {pitDcd, tcrDcd, tsrDcd} = sel;
    timerTic = tic;
    PCL_sprHold = hold;
    freezeTimersNEG = frz;
    EXE_sprDataBus = data;
    @(posedge CB);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] e_pit, input logic e_pis,
                     input logic e_pie, input logic e_are, input logic e_irq);
    n_vec++;
    if (pitL2 !== e_pit || tsrPisL2 !== e_pis || tcrPieL2 !== e_pie ||
        tcrAreL2 !== e_are || TIM_pitIntReq !== e_irq) begin
      n_err++;
      $display("FAIL %s: got pit=%h pis=%b pie=%b are=%b irq=%b, want pit=%h pis=%b pie=%b are=%b irq=%b",
               name, pitL2, tsrPisL2, tcrPieL2, tcrAreL2, TIM_pitIntReq,
               e_pit, e_pis, e_pie, e_are, e_irq);
    end
  endtask

  // Reference model state, advanced once per clock from the architectural rules.
  longint unsigned m_pit, m_reload;
  bit m_pie, m_are, m_pis;

  task automatic model_cycle(input bit mt, input bit [2:0] sel, input bit tic,
                             input bit hold, input bit frz, input bit [31:0] data);
    bit wp, wc, ws, expire;
    wp = mt && sel[2] && !hold;
    wc = mt && sel[1] && !hold;
    ws = mt && sel[0] && !hold;
    expire = 0;
    if (wp) begin
      m_pit = data;
      m_reload = data;
    end else if (tic && frz && m_pit != 0) begin
      if (m_pit == 1) begin
        expire = 1;
        m_pit = m_are ? m_reload : 0;
      end else begin
        m_pit = m_pit - 1;
      end
    end
    if (expire) m_pis = 1;
    else if (ws && ((data >> 27) & 1) == 1) m_pis = 0;
    if (wc) begin
      m_pie = ((data >> 26) & 1) == 1;
      m_are = ((data >> 22) & 1) == 1;
    end
  endtask

  initial begin
    // 0x04000000 sets PIE, 0x00400000 sets ARE, 0x08000000 hits PIS.
    tbl.push_back(mk(S_TCR,  0, 0, 32'h0440_0000 & 32'h0400_0000, 32'd0, 0, 1, 0, 0));
    tbl.push_back(mk(S_PIT,  0, 0, 32'd3,        32'd3, 0, 1, 0, 0));
    tbl.push_back(mk(S_NONE, 1, 0, 32'd0,        32'd2, 0, 1, 0, 0));
    tbl.push_back(mk(S_NONE, 1, 0, 32'd0,        32'd1, 0, 1, 0, 0));
    tbl.push_back(mk(S_NONE, 1, 0, 32'd0,        32'd0, 1, 1, 0, 1));
    tbl.push_back(mk(S_NONE, 1, 0, 32'd0,        32'd0, 1, 1, 0, 1));
    tbl.push_back(mk(S_TSR,  0, 0, 32'h0800_0000, 32'd0, 0, 1, 0, 0));
    tbl.push_back(mk(S_TCR,  0, 0, 32'h0440_0000, 32'd0, 0, 1, 1, 0));
    tbl.push_back(mk(S_PIT,  0, 0, 32'd2,        32'd2, 0, 1, 1, 0));
    tbl.push_back(mk(S_NONE, 1, 0, 32'd0,        32'd1, 0, 1, 1, 0));
    tbl.push_back(mk(S_NONE, 1, 0, 32'd0,        32'd2, 1, 1, 1, 1));
    tbl.push_back(mk(S_NONE, 1, 0, 32'd0,        32'd1, 1, 1, 1, 1));
    tbl.push_back(mk(S_NONE, 1, 0, 32'd0,        32'd2, 1, 1, 1, 1));
    tbl.push_back(mk(S_TSR,  0, 0, 32'h0800_0000, 32'd2, 0, 1, 1, 0));
    tbl.push_back(mk(S_NONE, 1, 0, 32'd0,        32'd1, 0, 1, 1, 0));
    tbl.push_back(mk(S_PIT,  1, 0, 32'h10,       32'h10, 0, 1, 1, 0));
    tbl.push_back(mk(S_PIT,  0, 0, 32'd1,        32'd1, 0, 1, 1, 0));
    tbl.push_back(mk(S_TSR,  1, 0, 32'h0800_0000, 32'd1, 1, 1, 1, 1));
    tbl.push_back(mk(S_TSR,  0, 0, 32'hF7FF_FFFF, 32'd1, 1, 1, 1, 1));
    tbl.push_back(mk(S_PIT,  0, 1, 32'd7,        32'd1, 1, 1, 1, 1));
    tbl.push_back(mk(S_TCR,  0, 0, 32'h0400_0000, 32'd1, 1, 1, 0, 1));
    tbl.push_back(mk(S_NONE, 1, 0, 32'd0,        32'd0, 1, 1, 0, 1));
    tbl.push_back(mk(S_TSR,  0, 0, 32'h0800_0000, 32'd0, 0, 1, 0, 0));
    tbl.push_back(mk(S_PIT,  0, 0, 32'd0,        32'd0, 0, 1, 0, 0));
    tbl.push_back(mk(S_NONE, 1, 0, 32'd0,        32'd0, 0, 1, 0, 0));
    tbl.push_back(mk(S_TCR,  0, 0, 32'd0,        32'd0, 0, 0, 0, 0));
    tbl.push_back(mk(S_PIT,  0, 0, 32'd1,        32'd1, 0, 0, 0, 0));
    tbl.push_back(mk(S_NONE, 1, 0, 32'd0,        32'd0, 1, 0, 0, 0));
    tbl.push_back(mk(S_TCR,  0, 0, 32'h0400_0000, 32'd0, 1, 1, 0, 1));
    tbl.push_back(mk(S_TSR,  0, 0, 32'hFFFF_FFFF, 32'd0, 0, 1, 0, 0));
    tbl.push_back(mk(S_PIT,  0, 0, 32'd1,        32'd1, 0, 1, 0, 0));
    tbl.push_back(mk(S_TCR,  1, 0, 32'h0440_0000, 32'd0, 1, 1, 1, 1));

    #1;
    chk("reset_async", 32'd0, 0, 0, 0, 0);
    @(posedge CB);
    #1;
    resetCore = 1'b0;
    chk("reset_state", 32'd0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].sel != S_NONE, tbl[i].sel, tbl[i].tic, tbl[i].hold, 1'b1, tbl[i].data);
      chk($sformatf("table_%0d", i), tbl[i].e_pit, tbl[i].e_pis, tbl[i].e_pie,
          tbl[i].e_are, tbl[i].e_irq);
    end

    // Freeze: ticks are ignored, SPR writes still land.
    step(1, S_TSR, 0, 0, 1, 32'h0800_0000);
    step(1, S_TCR, 0, 0, 1, 32'h0400_0000);
    step(1, S_PIT, 0, 0, 0, 32'd5);
    chk("freeze_write", 32'd5, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, S_NONE, 1, 0, 0, 32'd0);
      chk($sformatf("freeze_tick_%0d", i), 32'd5, 0, 1, 0, 0);
    end
    step(0, S_NONE, 1, 0, 1, 32'd0);
    chk("freeze_release", 32'd4, 0, 1, 0, 0);

    // Asynchronous reset mid-countdown with an interrupt pending.
    step(1, S_TCR, 0, 0, 1, 32'h0440_0000);
    step(1, S_PIT, 0, 0, 1, 32'd1);
    step(0, S_NONE, 1, 0, 1, 32'd0);
    chk("pre_reset_irq", 32'd1, 1, 1, 1, 1);
    step(1, S_PIT, 0, 0, 1, 32'h100);
    step(0, S_NONE, 1, 0, 1, 32'd0);
    chk("pre_reset_count", 32'hFF, 1, 1, 1, 1);
    #2;
    resetCore = 1'b1;
    #1;
    chk("reset_mid_count", 32'd0, 0, 0, 0, 0);
    @(posedge CB);
    #1;
    resetCore = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(0, S_NONE, 1, 0, 1, 32'd0);
      chk($sformatf("post_reset_tick_%0d", i), 32'd0, 0, 0, 0, 0);
    end

    // Random traffic against the reference model.
    m_pit = 0; m_reload = 0; m_pie = 0; m_are = 0; m_pis = 0;
    for (int i = 0; i < 600; i++) begin
      bit mt, tic, hold, frz;
      bit [2:0] sel;
      bit [31:0] data;
      int pick;
      mt   = ($urandom_range(0, 99) < 40);
      pick = $urandom_range(0, 3);
      sel  = (pick == 0) ? S_NONE : (pick == 1) ? S_PIT : (pick == 2) ? S_TCR : S_TSR;
      tic  = ($urandom_range(0, 99) < 60);
      hold = ($urandom_range(0, 99) < 15);
      frz  = ($urandom_range(0, 99) < 85);
      data = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 5));
      if (sel == S_TCR || sel == S_TSR) data = $urandom;
      model_cycle(mt, sel, tic, hold, frz, data);
      step(mt, sel, tic, hold, frz, data);
      chk($sformatf("random_%0d", i), m_pit[31:0], m_pis, m_pie, m_are, m_pis & m_pie);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
